// File: rtl/r5p_tcb_trace_fifo.sv
// ----------------------------------------------------------------------------
// r5p_tcb_trace_fifo
//
// Passive trace capture unit for the CPU TCB port. It watches completed bus
// transfers. Each transfer whose address falls inside
// [FLT_BGN, FLT_END] while capture is enabled becomes one record. A record holds
// the address, write flag, size and the cycle timestamp. Records are queued in a
// DEPTH-entry FIFO and drained over a valid/ready stream.
//
// The bus is never stalled. When the FIFO is full, a new record is dropped. A
// sticky overflow flag is set and a saturating drop counter is incremented.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   ena               capture enable (draining continues while low)
//   clr               synchronous flush: FIFO, drop counter, ovf, timestamp
//   tcb_trn           a bus transfer completes this cycle (vld & rdy)
//   tcb_wen/adr/siz   attributes of that transfer
//   trc_vld/trc_rdy   record stream handshake
//   trc_adr/wen/siz   record payload
//   trc_tim           record timestamp
//   trc_cnt           FIFO occupancy
//   trc_ovf           sticky: at least one record dropped
//   trc_drp           dropped record count (saturating)
//
// Handshake: a record is transferred on every cycle where trc_vld & trc_rdy
// is high. trc_vld never depends on trc_rdy. While trc_vld is high and
// trc_rdy is low, the payload holds steady. The payload reads as zero while
// the FIFO is empty.
// ----------------------------------------------------------------------------
module r5p_tcb_trace_fifo #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TW      = 16,
  parameter int unsigned DW      = 8,
  parameter logic [XLEN-1:0] FLT_BGN = 32'h8000_0000,
  parameter logic [XLEN-1:0] FLT_END = 32'h8000_3fff
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       clr,
  input  logic                       tcb_trn,
  input  logic                       tcb_wen,
  input  logic [XLEN-1:0]            tcb_adr,
  input  logic [1:0]                 tcb_siz,
  output logic                       trc_vld,
  input  logic                       trc_rdy,
  output logic [XLEN-1:0]            trc_adr,
  output logic                       trc_wen,
  output logic [1:0]                 trc_siz,
  output logic [TW-1:0]              trc_tim,
  output logic [$clog2(DEPTH):0]     trc_cnt,
  output logic                       trc_ovf,
  output logic [DW-1:0]              trc_drp
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = XLEN + 1 + 2 + TW;

  // Record storage is not reset. Outputs are masked while the FIFO is empty.
  logic [RW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [CW-1:0]   r_cnt;
  logic [TW-1:0]   r_tim;
  logic            r_ovf;
  logic [DW-1:0]   r_drp;

  logic            w_in_win;
  logic            w_cap;
  logic            w_full;
  logic            w_vld;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [RW-1:0]   w_rec;

  assign w_in_win = (tcb_adr >= FLT_BGN) && (tcb_adr <= FLT_END);
  assign w_cap    = ena & tcb_trn & w_in_win;
  assign w_full   = (r_cnt == CW'(DEPTH));
  assign w_vld    = (r_cnt != '0);
  assign w_pop    = w_vld & trc_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push   = w_cap & (~w_full | w_pop);
  assign w_drop   = w_cap & w_full & ~w_pop;

  // Free-running timestamp. It wraps naturally, and clr restarts it from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tim <= '0;
    end else if (clr) begin
      r_tim <= '0;
    end else begin
      r_tim <= r_tim + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !clr) begin
      r_mem[r_wp] <= {tcb_adr, tcb_wen, tcb_siz, r_tim};
    end
  end

  // Pointers, occupancy, overflow and drop count.
  // clr overrides any push, pop or drop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_drp <= '0;
    end else if (clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_drp <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drp != '1) begin
          r_drp <= r_drp + DW'(1);
        end
      end
    end
  end

  // First-word fall-through read from the head entry.
  assign w_rec = w_vld ? r_mem[r_rp] : '0;

  assign trc_vld = w_vld;
  assign trc_adr = w_rec[RW-1 -: XLEN];
  assign trc_wen = w_rec[TW+2];
  assign trc_siz = w_rec[TW+1 -: 2];
  assign trc_tim = w_rec[TW-1:0];
  assign trc_cnt = r_cnt;
  assign trc_ovf = r_ovf;
  assign trc_drp = r_drp;

endmodule

// File: tb/tb_r5p_tcb_trace_fifo.sv
// ----------------------------------------------------------------------------
// Bench for r5p_tcb_trace_fifo.
// Inputs are driven on the falling edge. Outputs are checked on the following
// falling edge. A reference model tracks the expected queue of records, the
// timestamp, the overflow flag and the drop count.
// ----------------------------------------------------------------------------
module tb_r5p_tcb_trace_fifo;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TW    = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned W     = XLEN + 1 + 2 + TW;

  // Clock/reset and DUT signals.
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ena = 1'b0;
  logic            clr = 1'b0;
  logic            tcb_trn = 1'b0;
  logic            tcb_wen = 1'b0;
  logic [XLEN-1:0] tcb_adr = '0;
  logic [1:0]      tcb_siz = '0;
  logic            trc_rdy = 1'b0;
  logic            trc_vld;
  logic [XLEN-1:0] trc_adr;
  logic            trc_wen;
  logic [1:0]      trc_siz;
  logic [TW-1:0]   trc_tim;
  logic [4:0]      trc_cnt;
  logic            trc_ovf;
  logic [DW-1:0]   trc_drp;

  always #5 clk = ~clk;

  r5p_tcb_trace_fifo dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .clr     (clr),
    .tcb_trn (tcb_trn),
    .tcb_wen (tcb_wen),
    .tcb_adr (tcb_adr),
    .tcb_siz (tcb_siz),
    .trc_vld (trc_vld),
    .trc_rdy (trc_rdy),
    .trc_adr (trc_adr),
    .trc_wen (trc_wen),
    .trc_siz (trc_siz),
    .trc_tim (trc_tim),
    .trc_cnt (trc_cnt),
    .trc_ovf (trc_ovf),
    .trc_drp (trc_drp)
  );

  // Scoreboard and reference model state.
  logic [W-1:0]  exp_q[$];
  logic [TW-1:0] m_tim = '0;
  logic          m_ovf = 1'b0;
  logic [DW-1:0] m_drp = '0;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] rec;
    check_val("vld", 32'(trc_vld), 32'(exp_q.size() != 0));
    check_val("cnt", 32'(trc_cnt), 32'(exp_q.size()));
    check_val("ovf", 32'(trc_ovf), 32'(m_ovf));
    check_val("drp", 32'(trc_drp), 32'(m_drp));
    if (exp_q.size() != 0) rec = exp_q[0];
    else rec = '0;
    check_val("adr", trc_adr, rec[W-1 -: XLEN]);
    check_val("wen", 32'(trc_wen), 32'(rec[TW+2]));
    check_val("siz", 32'(trc_siz), 32'(rec[TW+1 -: 2]));
    check_val("tim", 32'(trc_tim), 32'(rec[TW-1:0]));
  endtask

  // Driver: apply one cycle of stimulus at the current falling edge, advance
  // the model, then check the outputs on the next falling edge.
  task automatic step(input logic s_ena, input logic s_trn, input logic s_wen,
                      input logic [XLEN-1:0] s_adr, input logic [1:0] s_siz,
                      input logic s_rdy, input logic s_clr);
    logic cap, pop, full;
    ena = s_ena; tcb_trn = s_trn; tcb_wen = s_wen; tcb_adr = s_adr;
    tcb_siz = s_siz; trc_rdy = s_rdy; clr = s_clr;
    cap  = s_ena && s_trn && (s_adr >= 32'h8000_0000) && (s_adr <= 32'h8000_3fff);
    pop  = (exp_q.size() != 0) && s_rdy;
    full = (exp_q.size() == DEPTH);
    if (s_clr) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_drp = '0;
      m_tim = '0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (cap) begin
        if (!full || pop) exp_q.push_back({s_adr, s_wen, s_siz, m_tim});
        else begin
          m_ovf = 1'b1;
          if (m_drp != 8'hff) m_drp = m_drp + 8'd1;
        end
      end
      m_tim = m_tim + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic s_rdy);
    step(1'b1, 1'b0, 1'b0, '0, 2'd0, s_rdy, 1'b0);
  endtask

  task automatic capture(input logic [XLEN-1:0] a, input logic w, input logic [1:0] s,
                         input logic r);
    step(1'b1, 1'b1, w, a, s, r, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_outputs();

    // Single write captured at timestamp 5.
    repeat (5) idle(1'b1);
    capture(32'h8000_0010, 1'b1, 2'd2, 1'b1);
    check_val("single_vld", 32'(trc_vld), 32'd1);
    check_val("single_adr", trc_adr, 32'h8000_0010);
    check_val("single_tim", 32'(trc_tim), 32'd5);
    idle(1'b1);
    check_val("single_vld_after", 32'(trc_vld), 32'd0);

    // Window boundaries.
    capture(32'h7fff_fffc, 1'b0, 2'd2, 1'b0);
    capture(32'h8000_4000, 1'b0, 2'd2, 1'b0);
    capture(32'h8000_0000, 1'b0, 2'd0, 1'b0);
    capture(32'h8000_3fff, 1'b1, 2'd1, 1'b0);
    check_val("win_cnt", 32'(trc_cnt), 32'd2);
    idle(1'b1);
    idle(1'b1);

    // Overflow: 20 captures into a stalled FIFO.
    for (int i = 0; i < 20; i++) capture(32'h8000_0100 + 32'(4 * i), 1'b1, 2'd2, 1'b0);
    check_val("ovf_cnt", 32'(trc_cnt), 32'd16);
    check_val("ovf_flag", 32'(trc_ovf), 32'd1);
    check_val("ovf_drp", 32'(trc_drp), 32'd4);

    // Full FIFO with a simultaneous capture and pop.
    capture(32'h8000_0200, 1'b0, 2'd3, 1'b1);
    check_val("fullpop_cnt", 32'(trc_cnt), 32'd16);
    check_val("fullpop_drp", 32'(trc_drp), 32'd4);
    for (int i = 0; i < 16; i++) idle(1'b1);
    check_val("drain_cnt", 32'(trc_cnt), 32'd0);

    // Drop counter saturation, then clear with a discarded capture.
    for (int i = 0; i < 316; i++) capture(32'h8000_1000, 1'b1, 2'd2, 1'b0);
    check_val("sat_drp", 32'(trc_drp), 32'd255);
    step(1'b1, 1'b1, 1'b1, 32'h8000_0040, 2'd2, 1'b0, 1'b1);
    check_val("clr_cnt", 32'(trc_cnt), 32'd0);
    check_val("clr_ovf", 32'(trc_ovf), 32'd0);
    check_val("clr_drp", 32'(trc_drp), 32'd0);
    capture(32'h8000_0044, 1'b0, 2'd1, 1'b0);
    check_val("clr_tim", 32'(trc_tim), 32'd0);
    idle(1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [XLEN-1:0] a;
      if ($urandom_range(0, 3) == 0) a = $urandom();
      else a = 32'h8000_0000 + 32'($urandom_range(0, 32'h3fff));
      step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           a, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) == 0);
    end

    // Asynchronous reset with five records queued mid-drain.
    step(1'b0, 1'b0, 1'b0, '0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) capture(32'h8000_2000 + 32'(4 * i), 1'b1, 2'd2, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check_val("pre_rst_cnt", 32'(trc_cnt), 32'd5);
    rst = 1'b1;
    #1;
    check_val("rst_vld", 32'(trc_vld), 32'd0);
    check_val("rst_cnt", 32'(trc_cnt), 32'd0);
    exp_q.delete();
    m_ovf = 1'b0;
    m_drp = '0;
    m_tim = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
    check_val("post_rst_cnt", 32'(trc_cnt), 32'd0);
    capture(32'h8000_0008, 1'b1, 2'd2, 1'b0);
    check_val("post_rst_tim", 32'(trc_tim), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
